// File: rtl/mux_scan_serializer.sv
// Serialiser for an 8:1 mux stage: latches a word, steps the select 0..7 LSB-first.
// Optional even-parity bit after bit 7 when PARITY_EN is defined.
module mux_scan_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [2:0] s,
    output logic       o,
    output logic       o_valid,
    output logic       o_par,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);
    // Handshake: a word is taken on a rising edge where i_valid && i_ready;
    // i_ready is high only in IDLE, and i/i_valid are ignored otherwise.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    state_t           state, state_nx;
    logic [7:0]       data_reg, data_nx;
    logic [2:0]       s_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= 8'd0;
            s        <= 3'd0;
            cnt      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            data_reg <= data_nx;
            s        <= s_nx;
            cnt      <= cnt_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        data_nx  = data_reg;
        s_nx     = s;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    data_nx  = i;
                    s_nx     = 3'd0;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_nx = '0;
                    if (s == 3'd7) begin
`ifdef PARITY_EN
                        // select stays at 7 while the parity bit is on o
                        state_nx = PARITY;
`else
                        s_nx     = 3'd0;
                        state_nx = IDLE;
                        done_nx  = 1'b1;
`endif
                    end else begin
                        s_nx = s + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    s_nx     = 3'd0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                s_nx     = 3'd0;
                cnt_nx   = '0;
            end
        endcase
    end

    // All outputs below depend only on registered state.
    always_comb begin
        i_ready = (state == IDLE);
        busy    = (state != IDLE);
        o_valid = (state == SHIFT) || (state == PARITY);
        o       = 1'b0;
        if (state == SHIFT)
            o = data_reg[s];
        else if (state == PARITY)
            o = ^data_reg;
    end

`ifdef PARITY_EN
    assign o_par = (state == PARITY);
`else
    assign o_par = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed + randomized bench for mux_scan_serializer at BIT_CYCLES=1 and 4.
// Expected serial streams come from a per-word model built from the data word.
module tb_mux_scan_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i1, i4;
    logic       v1, v4;
    logic       r1, r4, o1, o4, ov1, ov4, p1, p4, b1, b4, d1, d4;
    logic [2:0] s1, s4;
    logic [1:0] st1, st4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_scan_serializer #(.BIT_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .i(i1), .i_valid(v1), .i_ready(r1), .s(s1), .o(o1),
        .o_valid(ov1), .o_par(p1), .busy(b1), .done(d1), .state_dbg(st1));

    mux_scan_serializer #(.BIT_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .i(i4), .i_valid(v4), .i_ready(r4), .s(s4), .o(o4),
        .o_valid(ov4), .o_par(p4), .busy(b4), .done(d4), .state_dbg(st4));

`ifdef PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit which, input logic vv, input logic [7:0] dd);
        if (which) begin v4 = vv; i4 = dd; end
        else       begin v1 = vv; i1 = dd; end
    endtask

    // Outputs packed: {o_valid, o, o_par, busy, done, i_ready}
    function automatic logic [5:0] flags(input bit which);
        if (which) return {ov4, o4, p4, b4, d4, r4};
        return {ov1, o1, p1, b1, d1, r1};
    endfunction

    function automatic logic [2:0] sel(input bit which);
        return which ? s4 : s1;
    endfunction

    // Called right after the accept edge. Checks every bit cycle and the done
    // cycle; with hold_next the following word is offered throughout.
    task automatic stream(input bit which, input logic [7:0] data,
                          input bit hold_next, input logic [7:0] nxt);
        int b;
        int pos;
        logic       eo;
        logic [2:0] es;
        logic       ep;
        b = which ? 4 : 1;
        for (int c = 0; c < NBITS * b; c++) begin
            @(negedge clk);
            pos = c / b;
            if (pos < 8) begin
                eo = data[pos];
                es = 3'(pos);
                ep = 1'b0;
            end else begin
                eo = 1'($countones(data) % 2);
                es = 3'd7;
                ep = 1'b1;
            end
            check($sformatf("bit%0d_s", c), {5'd0, sel(which)}, {5'd0, es});
            check($sformatf("bit%0d_flags", c), {2'd0, flags(which)},
                  {2'd0, 1'b1, eo, ep, 1'b1, 1'b0, 1'b0});
            if (hold_next) drive(which, 1'b1, nxt);
            else           drive(which, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        @(negedge clk);
        check("done_flags", {2'd0, flags(which)}, {2'd0, 6'b000011});
        check("done_s", {5'd0, sel(which)}, 8'd0);
        if (!hold_next) drive(which, 1'b0, 8'($urandom));
    endtask

    task automatic send(input bit which, input logic [7:0] data);
        @(negedge clk);
        drive(which, 1'b1, data);
        check("accept_ready", {7'd0, which ? r4 : r1}, 8'd1);
        @(posedge clk);
        stream(which, data, 1'b0, 8'd0);
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1;
        v1 = 1'b0; v4 = 1'b0; i1 = 8'd0; i4 = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset while idle, checked before any edge
        #2 rst = 1'b1;
        #1;
        check("rst_idle_s", {5'd0, s1}, 8'd0);
        check("rst_idle_flags", {2'd0, flags(1'b0)}, {2'd0, 6'b000001});
        @(negedge clk);
        rst = 1'b0;

        // B=1 word, then back-to-back accepted in the done cycle
        send(1'b0, 8'b10101100);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'b10101100);
        @(posedge clk);
        stream(1'b0, 8'b10101100, 1'b1, 8'b01010011);
        @(posedge clk);
        stream(1'b0, 8'b01010011, 1'b0, 8'd0);

        // B=4 word
        send(1'b1, 8'hA5);
        send(1'b1, 8'b10101101);

        // Reset mid-word after bit 3: immediate clear, no done afterwards
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF);
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 8'h00);
            check("ff_bit", {5'd0, s1, o1}, {4'd0, 3'(c), 1'b1});
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_s", {5'd0, s1}, 8'd0);
        check("rst_mid_flags", {2'd0, flags(1'b0)}, {2'd0, 6'b000001});
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_rst", {7'd0, d1}, 8'd0);
        end
        send(1'b0, 8'h01);

        // rst together with i_valid: word must not be taken
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("rst_wins_busy", {7'd0, b1}, 8'd0);

        // Randomized words on both instances, random idle gaps
        for (int n = 0; n < 16; n++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom_range(0, 1)), w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
